// File: rtl/tff_chk_pkg.sv
// Shared types and defaults for the TFF/DFF response checker.
package tff_chk_pkg;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/tff_resp_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/tff_resp_checker.sv
// Observes TFF/DFF outputs against stimulus t over a programmed window and
// reports saturating mismatch counts, first mismatch index and pass/fail.
module tff_resp_checker
    import tff_chk_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic             t,
    input  logic             q_t,
    input  logic             q_d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt_t,
    output logic [CNT_W-1:0] err_cnt_d,
    output logic             err_seen,
    output logic [CNT_W-1:0] first_err_idx
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_first_idx;
    logic             r_ref_t;
    logic             r_ref_d;
    logic             r_err_seen;
    logic             w_accept;
    logic             w_mis_t;
    logic             w_mis_d;
    logic             w_last;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mis_t  = (r_state == CHECK) && (q_t != r_ref_t);
    assign w_mis_d  = (r_state == CHECK) && (q_d != r_ref_d);
    // r_len is never 0 in CHECK, so the wrap of r_len-1 is unreachable there.
    assign w_last   = (r_idx == (r_len - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SYNC;
            SYNC:    w_next = (r_len != '0) ? CHECK : DONE;
            CHECK:   if (w_last) w_next = DONE;
            DONE:    if (start) w_next = SYNC;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SYNC) || (r_state == CHECK);
        done = (r_state == DONE);
        pass = (r_state == DONE) && (err_cnt_t == '0) && (err_cnt_d == '0);
    end

    // Prediction is relational: next q_t is expected to be observed q_t ^ t.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_first_idx <= '0;
            r_ref_t     <= 1'b0;
            r_ref_d     <= 1'b0;
            r_err_seen  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len       <= num_cycles;
                r_first_idx <= '0;
                r_err_seen  <= 1'b0;
            end
            if (r_state == SYNC) begin
                r_ref_t <= q_t ^ t;
                r_ref_d <= t;
                r_idx   <= '0;
            end
            if (r_state == CHECK) begin
                r_ref_t <= q_t ^ t;
                r_ref_d <= t;
                if ((w_mis_t || w_mis_d) && !r_err_seen) begin
                    r_first_idx <= r_idx;
                    r_err_seen  <= 1'b1;
                end
                if (!w_last) begin
                    r_idx <= r_idx + CNT_W'(1);
                end
            end
        end
    end

    sat_cnt #(.W(CNT_W)) u_cnt_t (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_accept),
        .i_inc (w_mis_t),
        .o_cnt (err_cnt_t)
    );

    sat_cnt #(.W(CNT_W)) u_cnt_d (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_accept),
        .i_inc (w_mis_d),
        .o_cnt (err_cnt_d)
    );

    assign err_seen      = r_err_seen;
    assign first_err_idx = r_first_idx;
endmodule

// File: tb/tb_tff_resp_checker.sv
// Bench for tff_resp_checker: table vectors, random windows vs a reference
// model, and hand-written reset/restart/saturation sequences.
module tb_tff_resp_checker;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, t, q_t, q_d;
    logic [7:0] num_cycles;
    logic       busy, done, pass, err_seen;
    logic [7:0] err_cnt_t, err_cnt_d, first_err_idx;

    logic       start4;
    logic [3:0] num4;
    logic       busy4, done4, pass4, err_seen4;
    logic [3:0] err_cnt_t4, err_cnt_d4, first_err_idx4;

    logic       sc_clr, sc_inc;
    logic [2:0] sc_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic tv  [0:299];
    logic qtv [0:299];
    logic qdv [0:299];

    typedef struct {
        int len; int tk; int fk; int et; int ed; int fi; int ps;
    } vec_t;
    vec_t tbl [7];

    tff_resp_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles),
        .t(t), .q_t(q_t), .q_d(q_d), .busy(busy), .done(done), .pass(pass),
        .err_cnt_t(err_cnt_t), .err_cnt_d(err_cnt_d), .err_seen(err_seen),
        .first_err_idx(first_err_idx)
    );

    tff_resp_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .num_cycles(num4),
        .t(t), .q_t(q_t), .q_d(q_d), .busy(busy4), .done(done4), .pass(pass4),
        .err_cnt_t(err_cnt_t4), .err_cnt_d(err_cnt_d4), .err_seen(err_seen4),
        .first_err_idx(first_err_idx4)
    );

    sat_cnt #(.W(3)) u_sc (
        .i_clk(clk), .i_rst(rst), .i_clr(sc_clr), .i_inc(sc_inc), .o_cnt(sc_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // tk: 0 fixed pattern, 1 all ones, 2 all zeros, 3 random
    // fk: 0 none, 1 q_t stuck 0, 2 q_d flipped at compare 5, 3 q_d stuck 1,
    //     4 q_t stuck 1, 5 random flips on either output
    task automatic build(input int len, input int tk, input int fk);
        logic [15:0] pat;
        pat = 16'h4DC4;
        for (int j = 0; j <= len; j++) begin
            case (tk)
                0:       tv[j] = pat[j % 16];
                1:       tv[j] = 1'b1;
                2:       tv[j] = 1'b0;
                default: tv[j] = 1'($urandom_range(0, 1));
            endcase
        end
        qtv[0] = 1'b0;
        qdv[0] = 1'b0;
        for (int j = 1; j <= len; j++) begin
            qtv[j] = qtv[j-1] ^ tv[j-1];
            qdv[j] = tv[j-1];
        end
        for (int j = 0; j <= len; j++) begin
            case (fk)
                1: qtv[j] = 1'b0;
                2: if (j == 6) qdv[j] = ~qdv[j];
                3: qdv[j] = 1'b1;
                4: qtv[j] = 1'b1;
                5: begin
                    if (j > 0 && $urandom_range(0, 7) == 0) qtv[j] = ~qtv[j];
                    if (j > 0 && $urandom_range(0, 7) == 0) qdv[j] = ~qdv[j];
                end
                default: ;
            endcase
        end
    endtask

    // Compare i sees the sample after i; the prediction comes from sample i.
    task automatic ref_model(input int len, input int maxv,
                             output int et, output int ed, output int fi, output int seen);
        et = 0; ed = 0; fi = 0; seen = 0;
        for (int i = 0; i < len; i++) begin
            int mt, md;
            mt = (qtv[i+1] != (qtv[i] ^ tv[i])) ? 1 : 0;
            md = (qdv[i+1] != tv[i]) ? 1 : 0;
            if ((mt + md) > 0 && seen == 0) begin
                seen = 1;
                fi   = i;
            end
            et += mt;
            ed += md;
        end
        if (et > maxv) et = maxv;
        if (ed > maxv) ed = maxv;
    endtask

    task automatic run_window(input string tag, input int len, input bit stray);
        @(posedge clk); #1;
        start      = 1'b1;
        num_cycles = 8'(len);
        @(posedge clk); #1;
        start      = 1'b0;
        num_cycles = 8'($urandom_range(0, 255));
        chk({tag, " busy_rise"}, busy, 1);
        for (int j = 0; j <= len; j++) begin
            t   = tv[j];
            q_t = qtv[j];
            q_d = qdv[j];
            start = stray && (j == 0 || j == len);
            if (j == len) chk({tag, " done_early"}, done, 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, " done_lat"}, done, 1);
    endtask

    task automatic check_results(input string tag, input int et, input int ed,
                                 input int fi, input int ps);
        chk({tag, " err_cnt_t"}, err_cnt_t, et);
        chk({tag, " err_cnt_d"}, err_cnt_d, ed);
        chk({tag, " err_seen"}, err_seen, ((et + ed) != 0) ? 1 : 0);
        chk({tag, " first_idx"}, first_err_idx, fi);
        chk({tag, " pass"}, pass, ps);
    endtask

    initial begin
        int et, ed, fi, seen, lat, len, dcount;
        string tag;

        tbl[0] = '{20,  0, 0, 0,   0, 0, 1};
        tbl[1] = '{10,  1, 1, 10,  0, 0, 0};
        tbl[2] = '{12,  0, 2, 0,   1, 5, 0};
        tbl[3] = '{8,   2, 3, 0,   8, 0, 0};
        tbl[4] = '{6,   2, 4, 0,   0, 0, 1};
        tbl[5] = '{20,  0, 1, 8,   0, 2, 0};
        tbl[6] = '{255, 1, 1, 255, 0, 0, 0};

        rst = 1'b1; start = 1'b0; start4 = 1'b0; num_cycles = '0; num4 = '0;
        t = 1'b0; q_t = 1'b0; q_d = 1'b0; sc_clr = 1'b0; sc_inc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst err_cnt_t", err_cnt_t, 0);
        chk("rst err_cnt_d", err_cnt_d, 0);
        chk("rst err_seen", err_seen, 0);
        chk("rst first_idx", first_err_idx, 0);
        chk("rst busy4", busy4, 0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            tag = $sformatf("tbl%0d", k);
            build(tbl[k].len, tbl[k].tk, tbl[k].fk);
            run_window(tag, tbl[k].len, (k % 2) == 0);
            check_results(tag, tbl[k].et, tbl[k].ed, tbl[k].fi, tbl[k].ps);
        end

        for (int r = 0; r < 12; r++) begin
            tag = $sformatf("rnd%0d", r);
            len = $urandom_range(1, 40);
            build(len, 3, (r % 4 == 3) ? 0 : 5);
            ref_model(len, 255, et, ed, fi, seen);
            run_window(tag, len, (r % 2) == 1);
            check_results(tag, et, ed, fi, ((et + ed) == 0) ? 1 : 0);
        end

        // Zero-length window from a failing DONE: results clear on accept.
        build(4, 1, 1);
        run_window("pre0", 4, 1'b0);
        chk("pre0 err_cnt_t", err_cnt_t, 4);
        @(posedge clk); #1;
        start = 1'b1; num_cycles = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0 busy", busy, 1);
        chk("len0 done_cleared", done, 0);
        chk("len0 cnt_cleared", err_cnt_t, 0);
        chk("len0 seen_cleared", err_seen, 0);
        @(posedge clk); #1;
        chk("len0 done", done, 1);
        chk("len0 pass", pass, 1);
        build(3, 0, 0);
        run_window("restart", 3, 1'b0);
        check_results("restart", 0, 0, 0, 1);

        // Reset while the compare index is 4.
        build(10, 1, 1);
        @(posedge clk); #1;
        start = 1'b1; num_cycles = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j <= 4; j++) begin
            t = tv[j]; q_t = qtv[j]; q_d = qdv[j];
            @(posedge clk); #1;
        end
        chk("midrst pre_cnt", err_cnt_t, 4);
        rst = 1'b1;
        t = tv[5]; q_t = qtv[5]; q_d = qdv[5];
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst pass", pass, 0);
        chk("midrst err_cnt_t", err_cnt_t, 0);
        chk("midrst err_seen", err_seen, 0);
        chk("midrst first_idx", first_err_idx, 0);
        dcount = 0;
        for (int j = 0; j < 15; j++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("midrst stays_idle", dcount, 0);
        rst = 1'b1; start = 1'b1; num_cycles = 8'd3;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_wins busy", busy, 0);

        // Longest 4-bit window, run twice: 15 errors, counters cleared between runs.
        t = 1'b1; q_t = 1'b0; q_d = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tag = $sformatf("w4run%0d", r);
            @(posedge clk); #1;
            start4 = 1'b1; num4 = 4'd15;
            @(posedge clk); #1;
            start4 = 1'b0;
            lat = 1;
            while (!done4 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            chk({tag, " done_lat"}, lat, 17);
            chk({tag, " err_cnt_t"}, err_cnt_t4, 15);
            chk({tag, " err_cnt_d"}, err_cnt_d4, 0);
            chk({tag, " first_idx"}, first_err_idx4, 0);
            chk({tag, " pass"}, pass4, 0);
        end

        // Counter saturation at 2^W-1.
        sc_clr = 1'b1;
        @(posedge clk); #1;
        sc_clr = 1'b0; sc_inc = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("sat mid", sc_cnt, 5);
        repeat (5) @(posedge clk);
        #1;
        chk("sat top", sc_cnt, 7);
        sc_inc = 1'b0; sc_clr = 1'b1;
        @(posedge clk); #1;
        sc_clr = 1'b0;
        chk("sat clr", sc_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
